// File: rtl/bus_wait_state_ctrl_if.sv
// Access request/response bundle between a bus master and the wait-state controller.
// The master side also drives the region decode and the off-chip ready line.
interface bus_wait_state_ctrl_if #(
  parameter int NUM_REGIONS = 4
) ();
  localparam int RSEL_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_addr;
  logic [7:0]        mem_wdata;
  logic [RSEL_W-1:0] region_sel;
  logic              region_ext;
  logic              ext_ready;
  logic              mem_ready;
  logic              bus_error;
  logic              cfg_hit;
  logic [7:0]        cfg_rdata;

  modport master (
    output mem_read, mem_write, mem_addr, mem_wdata, region_sel, region_ext, ext_ready,
    input  mem_ready, bus_error, cfg_hit, cfg_rdata
  );

  modport slave (
    input  mem_read, mem_write, mem_addr, mem_wdata, region_sel, region_ext, ext_ready,
    output mem_ready, bus_error, cfg_hit, cfg_rdata
  );
endinterface

// File: rtl/bus_wait_state_ctrl.sv
// Per-region wait-state generator with a byte-addressed config window holding the wait counts.
// Ready comes from a counter (internal regions) or ext_ready with a timeout (external regions).
module bus_wait_state_ctrl #(
  parameter int               NUM_REGIONS = 4,
  parameter int               CNT_W       = 16,
  parameter logic [31:0]      CFG_BASE    = 32'h1A10FF80,
  parameter logic [CNT_W-1:0] RESET_WAIT  = 16'h0005,
  parameter logic [CNT_W-1:0] TIMEOUT     = 16'h0FFF
) (
  input logic                  clk,
  input logic                  rst,
  bus_wait_state_ctrl_if.slave bus
);
  localparam int               RSEL_W     = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
  localparam logic [CNT_W-1:0] LOW16_MASK = CNT_W'(16'hFFFF);

  typedef enum logic [1:0] {IDLE, WAIT, RECOVER} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] w_q;
  logic             ext_q;
  logic             err_q;
  logic [CNT_W-1:0] wait_q [NUM_REGIONS];
  logic [CNT_W-1:0] wait_d [NUM_REGIONS];

  logic             req;
  logic             ready;
  logic             error;
  logic [31:0]      cfg_off;
  logic             cfg_hit;
  logic [3:0]       cfg_reg;
  logic [1:0]       cfg_byte;
  logic             cfg_wr;
  logic [15:0]      rd16;
  logic [15:0]      wr16;
  logic [7:0]       cfg_rdata;
  logic [CNT_W-1:0] sel_wait;

  assign req = bus.mem_read | bus.mem_write;

  // Window spans 16 region slots; unsigned wrap makes addresses below the base miss.
  assign cfg_off  = bus.mem_addr - CFG_BASE;
  assign cfg_hit  = (cfg_off[31:6] == 26'd0);
  assign cfg_reg  = cfg_off[5:2];
  assign cfg_byte = cfg_off[1:0];

  always_comb begin
    rd16 = 16'h0000;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (cfg_reg == 4'(i)) rd16 = 16'(wait_q[i]);
    end
    cfg_rdata = 8'h00;
    if (cfg_hit && !cfg_byte[1]) cfg_rdata = cfg_byte[0] ? rd16[15:8] : rd16[7:0];
  end

  always_comb begin
    sel_wait = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (bus.region_sel == RSEL_W'(i)) sel_wait = wait_q[i];
    end
  end

  always_comb begin
    ready = 1'b0;
    error = 1'b0;
    if (state_q == WAIT && req) begin
      if (err_q) begin
        ready = 1'b1;
        error = 1'b1;
      end else if (ext_q) begin
        if (bus.ext_ready) begin
          ready = 1'b1;
        end else if (cnt_q == TIMEOUT) begin
          ready = 1'b1;
          error = 1'b1;
        end
      end else if (cnt_q == w_q) begin
        ready = 1'b1;
      end
    end
  end

  assign bus.mem_ready = ready;
  assign bus.bus_error = error;
  assign bus.cfg_hit   = cfg_hit;
  assign bus.cfg_rdata = cfg_rdata;

  // Bytes 0/1 cover the low 16 bits of a wait register; wider counters keep their upper bits.
  assign cfg_wr = ready && !error && bus.mem_write && !bus.mem_read && cfg_hit && !cfg_byte[1];

  always_comb begin
    wr16 = cfg_byte[0] ? {bus.mem_wdata, rd16[7:0]} : {rd16[15:8], bus.mem_wdata};
    for (int i = 0; i < NUM_REGIONS; i++) begin
      wait_d[i] = wait_q[i];
      if (cfg_wr && cfg_reg == 4'(i)) begin
        wait_d[i] = (wait_q[i] & ~LOW16_MASK) | (CNT_W'(wr16) & LOW16_MASK);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      w_q     <= '0;
      ext_q   <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < NUM_REGIONS; i++) wait_q[i] <= RESET_WAIT;
    end else begin
      for (int i = 0; i < NUM_REGIONS; i++) wait_q[i] <= wait_d[i];
      case (state_q)
        IDLE: begin
          if (req) begin
            state_q <= WAIT;
            cnt_q   <= '0;
            err_q   <= bus.mem_read & bus.mem_write;
            // Config accesses always complete on-chip with zero waits.
            ext_q   <= bus.region_ext & ~cfg_hit;
            w_q     <= cfg_hit ? '0 : sel_wait;
          end
        end
        WAIT: begin
          if (!req) begin
            state_q <= IDLE;
          end else if (ready) begin
            state_q <= RECOVER;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RECOVER: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/bus_wait_state_ctrl.md
BUS_WAIT_STATE_CTRL -- requirements
Module: bus_wait_state_ctrl

Interface
REQ-001 SHALL take parameter NUM_REGIONS, default 4: number of wait-state regions (2..16).
REQ-002 SHALL take parameter CNT_W, default 16: width of wait counters and wait registers.
REQ-003 SHALL take parameter CFG_BASE, default 32'h1A10FF80: byte address of the config window, 4 bytes per region.
REQ-004 SHALL take parameter RESET_WAIT, default 16'h0005: reset value of every region wait register.
REQ-005 SHALL take parameter TIMEOUT, default 16'h0FFF: external-ready timeout in cycles.
REQ-006 SHALL take clock clk: clk input 1, rising-edge.
REQ-007 SHALL take reset rst: rst input 1, asynchronous, active-high.
REQ-008 SHALL take mem_read: input 1, slave-side read request, level, held until mem_ready.
REQ-009 SHALL take mem_write: input 1, slave-side write request, level, held until mem_ready.
REQ-010 SHALL take mem_addr: input 32, access address.
REQ-011 SHALL take mem_wdata: input 8, write data.
REQ-012 SHALL take region_sel: input clog2(NUM_REGIONS), decoded region of current access.
REQ-013 SHALL take region_ext: input 1, region uses external ready (off-chip).
REQ-014 SHALL take ext_ready: input 1, external device ready.
REQ-015 SHALL drive mem_ready: output 1, one-cycle access-complete strobe.
REQ-016 SHALL drive bus_error: output 1, one-cycle error strobe, coincident with mem_ready.
REQ-017 SHALL drive cfg_hit: output 1, mem_addr lies inside the config window.
REQ-018 SHALL drive cfg_rdata: output 8, config readback byte, valid while cfg_hit && mem_read.

Function
REQ-019 SHALL implement FSM states IDLE, WAIT, RECOVER.
REQ-020 IDLE: on mem_read^mem_write, SHALL latch region_sel, region_ext and the wait value W (W=0 if cfg_hit, else the region register); counter cleared; next state WAIT.
REQ-021 IDLE with mem_read&&mem_write SHALL go to WAIT with an error flag latched; in its first WAIT cycle mem_ready=bus_error=1.
REQ-022 WAIT, internal region: counter increments each cycle; mem_ready SHALL be combinational, high when counter==W; W=0 gives ready in the first WAIT cycle.
REQ-023 WAIT, external region: mem_ready SHALL equal ext_ready; when counter==TIMEOUT without ext_ready, mem_ready=bus_error=1.
REQ-024 Counter SHALL saturate at all-ones, never wrap.
REQ-025 Any cycle with mem_ready=1 SHALL transition WAIT->RECOVER; RECOVER SHALL last exactly one cycle, ignore requests, then go to IDLE.
REQ-026 WAIT with mem_read=mem_write=0 (aborted request) SHALL return to IDLE without mem_ready and without register updates.
REQ-027 Config write: byte k (0..1 used, 2..3 reserved) of region r at CFG_BASE+4r+k SHALL update in the mem_ready cycle, taking effect on the next access.
REQ-028 Reserved bytes and r>=NUM_REGIONS SHALL read 8'h00 and ignore writes.
REQ-029 cfg_rdata SHALL be combinational from mem_addr and SHALL be 8'h00 when not cfg_hit.
REQ-030 A config write SHALL NOT change W of the access in progress.

Reset
REQ-031 On rst: state IDLE, counter 0, error flag 0, all wait registers RESET_WAIT; mem_ready=bus_error=0.
REQ-032 rst mid-WAIT SHALL abort immediately, with no mem_ready emitted.

Verification
REQ-033 Reset, region 1 internal, read held -> mem_ready in 6th WAIT cycle (W=5), then 1 RECOVER cycle.
REQ-034 Write 8'h00,8'h00 to CFG_BASE+8/+9, then read region 2 -> mem_ready in first WAIT cycle; cfg_rdata at CFG_BASE+8 = 8'h00.
REQ-035 External region, ext_ready at WAIT cycle 3 -> mem_ready cycle 3, bus_error 0.
REQ-036 External region, ext_ready never -> mem_ready=bus_error=1 at counter==12'hFFF.
REQ-037 mem_read&&mem_write asserted -> bus_error=mem_ready=1 one cycle after request.
REQ-038 Read dropped at WAIT cycle 2 with W=5 -> IDLE next cycle, no mem_ready; rst asserted mid-WAIT -> IDLE, registers RESET_WAIT.
